// File: rtl/fp64_to_fixpkt.sv
// -----------------------------------------------------------------------------
// fp64_to_fixpkt
//
// Converts one IEEE-754 binary64 value per transfer into the segmented
// fixed-point packet {sign, msb, lmb, expo_cs} consumed by the accumulator
// lanes. The packet value is
//   (-1)^sign * (msb*2^64 + lmb) * 2^(64*expo_cs - 1140)
// and is decoded bit-exactly by the downstream packet-to-fp64 normaliser.
//
// Two-stage pipeline (unpack, shift/pack) with full valid/ready backpressure.
// Latency is 2 cycles and throughput is 1 transfer/cycle.
//
// Ports:
//   clk                    clock
//   rstn                   asynchronous active-low reset
//   fp64_in_stream_tvalid  input beat valid
//   fp64_in_stream_tready  input beat ready (combinational from downstream)
//   fp64_in_stream_tdata   binary64 value
//   ptk_out_stream_tvalid  output packet valid (registered)
//   ptk_out_stream_tready  output packet ready
//   ptk_out_stream_tdata   packet: [4:0] expo_cs, [132:5] lmb,
//                          [260:133] msb, [261] sign (registered)
//   special_flag           (FP64_SPECIAL_FLAG_EN only) 1 when the beat on the
//                          output came from an inf/NaN input
//
// Build option:
//   FP64_SPECIAL_FLAG_EN   adds the special_flag output. Without it, inf/NaN
//                          inputs are silently saturated to the max-normal
//                          packet.
//
// Only PRE_REG_WIDTH = 128, PRE_REG_STEP = 64 and DEPTH = 32 are supported.
// -----------------------------------------------------------------------------
module fp64_to_fixpkt #(
  parameter  int PRE_REG_WIDTH = 128,
  parameter  int DEPTH         = 32,
  parameter  int PRE_REG_STEP  = 64,
  localparam int EW            = $clog2(DEPTH - 1),
  localparam int OW            = EW + 2 * PRE_REG_WIDTH + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          fp64_in_stream_tvalid,
  output logic          fp64_in_stream_tready,
  input  logic [63:0]   fp64_in_stream_tdata,
  output logic          ptk_out_stream_tvalid,
  input  logic          ptk_out_stream_tready,
`ifdef FP64_SPECIAL_FLAG_EN
  output logic          special_flag,
`endif
  output logic [OW-1:0] ptk_out_stream_tdata
);

  localparam int FW = PRE_REG_WIDTH + PRE_REG_STEP;  // shifted mantissa width

  // Largest finite magnitude: (2^53-1) << 63 in the msb field, top segment.
  localparam logic [PRE_REG_WIDTH-1:0] SAT_MSB  = {12'd0, {53{1'b1}}, 63'd0};
  localparam logic [EW-1:0]            SAT_EXPO = EW'(DEPTH - 1);

  // ---------------------------------------------------------------------------
  // Pipeline advance: both stages move whenever stage 2 is empty or draining.
  // ---------------------------------------------------------------------------
  logic adv;
  logic s2_valid;

  assign adv                   = !s2_valid || ptk_out_stream_tready;
  assign fp64_in_stream_tready = adv;

  // ---------------------------------------------------------------------------
  // Stage 1: unpack
  // ---------------------------------------------------------------------------
  logic        in_sign;
  logic [10:0] in_exp;
  logic [51:0] in_frac;
  logic [10:0] exp_eff;
  logic [11:0] t_pos;
  logic [52:0] u_m;
  logic [6:0]  u_sh;
  logic [EW-1:0] u_k;
  logic        u_zero;
  logic        u_special;

  assign in_sign = fp64_in_stream_tdata[63];
  assign in_exp  = fp64_in_stream_tdata[62:52];
  assign in_frac = fp64_in_stream_tdata[51:0];

  // Subnormals share the exponent of the smallest normal.
  assign exp_eff = (in_exp == 11'd0) ? 11'd1 : in_exp;
  assign t_pos   = {1'b0, exp_eff} + 12'd1;
  assign u_m     = {(in_exp != 11'd0), in_frac};

  // The first segment absorbs every t below 64; above that, segment index is
  // t/64 and the residual shift lands in [64,127] so the mantissa straddles
  // the msb/lmb boundary.
  assign u_k  = (t_pos < 12'd64) ? EW'(1) : t_pos[10:6];
  assign u_sh = (t_pos < 12'd64) ? t_pos[6:0] : {1'b1, t_pos[5:0]};

  assign u_zero    = (in_exp == 11'd0) && (in_frac == 52'd0);
  // Only e == 2047 reaches t == 2048.
  assign u_special = t_pos[11];

  logic          s1_valid;
  logic          s1_sign;
  logic [52:0]   s1_m;
  logic [6:0]    s1_sh;
  logic [EW-1:0] s1_k;
  logic          s1_zero;
  logic          s1_special;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_m       <= '0;
      s1_sh      <= '0;
      s1_k       <= '0;
      s1_zero    <= 1'b0;
      s1_special <= 1'b0;
    end else if (adv) begin
      s1_valid   <= fp64_in_stream_tvalid;
      s1_sign    <= in_sign;
      s1_m       <= u_m;
      s1_sh      <= u_sh;
      s1_k       <= u_k;
      s1_zero    <= u_zero;
      s1_special <= u_special;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: shift and pack
  // ---------------------------------------------------------------------------
  // Highest set bit is 52 + 127 = 179, so the 192-bit field cannot overflow.
  logic [FW-1:0]            f_full;
  logic [PRE_REG_WIDTH-1:0] pk_msb;
  logic [PRE_REG_WIDTH-1:0] pk_lmb;
  logic [EW-1:0]            pk_expo;

  assign f_full = {{(FW - 53){1'b0}}, s1_m} << s1_sh;

  always_comb begin
    pk_msb  = f_full[FW-1:PRE_REG_STEP];
    pk_lmb  = {{(PRE_REG_WIDTH - PRE_REG_STEP){1'b0}}, f_full[PRE_REG_STEP-1:0]};
    pk_expo = s1_k;
    if (s1_zero) begin
      pk_msb  = '0;
      pk_lmb  = '0;
      pk_expo = '0;
    end else if (s1_special) begin
      pk_msb  = SAT_MSB;
      pk_lmb  = '0;
      pk_expo = SAT_EXPO;
    end
  end

  logic [OW-1:0] s2_data;
  logic          s2_special;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid   <= 1'b0;
      s2_data    <= '0;
      s2_special <= 1'b0;
    end else if (adv) begin
      s2_valid   <= s1_valid;
      s2_data    <= {s1_sign, pk_msb, pk_lmb, pk_expo};
      s2_special <= s1_special && !s1_zero;
    end
  end

  assign ptk_out_stream_tvalid = s2_valid;
  assign ptk_out_stream_tdata  = s2_data;

`ifdef FP64_SPECIAL_FLAG_EN
  assign special_flag = s2_special;
`else
  // Flag is still tracked so both builds share one datapath; it simply has
  // no observer here.
  logic unused_special;
  assign unused_special = s2_special;
`endif

endmodule

// File: tb/tb_fp64_to_fixpkt.sv
module tb_fp64_to_fixpkt;

  localparam int OW = 262;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_tvalid;
  logic          in_tready;
  logic [63:0]   in_tdata;
  logic          out_tvalid;
  logic          out_tready;
  logic [OW-1:0] out_tdata;
`ifdef FP64_SPECIAL_FLAG_EN
  logic          special_flag;
`endif

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [OW-1:0] exp_q[$];
  int            acc_q[$];
  bit            flag_q[$];

  fp64_to_fixpkt dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .fp64_in_stream_tvalid (in_tvalid),
    .fp64_in_stream_tready (in_tready),
    .fp64_in_stream_tdata  (in_tdata),
    .ptk_out_stream_tvalid (out_tvalid),
    .ptk_out_stream_tready (out_tready),
`ifdef FP64_SPECIAL_FLAG_EN
    .special_flag          (special_flag),
`endif
    .ptk_out_stream_tdata  (out_tdata)
  );

  always #5 clk = ~clk;
  always @(negedge clk) cyc <= cyc + 1;

  function automatic logic [OW-1:0] mk(input bit s, input logic [127:0] msb,
                                       input logic [127:0] lmb, input logic [4:0] ex);
    return {s, msb, lmb, ex};
  endfunction

  function automatic logic [127:0] sat_msb();
    return ((128'd1 << 53) - 128'd1) << 63;
  endfunction

  // Reference: the mantissa LSB sits at bit (Ee + 65) above 2^-1140; the
  // chosen segment k removes 64*k of that.
  function automatic logic [OW-1:0] ref_pkt(input logic [63:0] x);
    int e, ee, k, sh;
    logic [52:0]  m;
    logic [191:0] f;
    e = int'(x[62:52]);
    if (e == 0 && x[51:0] == 52'd0) return mk(x[63], 128'd0, 128'd0, 5'd0);
    if (e == 2047) return mk(x[63], sat_msb(), 128'd0, 5'd31);
    ee = (e == 0) ? 1 : e;
    m  = {(e != 0), x[51:0]};
    k  = (ee + 1 < 64) ? 1 : (ee + 1) / 64;
    sh = ee + 65 - 64 * k;
    f  = 192'(m) << sh;
    return mk(x[63], f[191:64], {64'd0, f[63:0]}, 5'(k));
  endfunction

  task automatic test_reset();
    rstn       = 1'b0;
    in_tvalid  = 1'b0;
    in_tdata   = 64'd0;
    out_tready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    compared++;
    if (out_tvalid !== 1'b0) begin
      mismatched++; $display("FAIL reset_tvalid: got %b want 0", out_tvalid);
    end
    compared++;
    if (out_tdata !== '0) begin
      mismatched++; $display("FAIL reset_tdata: got %h want 0", out_tdata);
    end
    compared++;
    if (in_tready !== 1'b1) begin
      mismatched++; $display("FAIL reset_in_tready: got %b want 1", in_tready);
    end
`ifdef FP64_SPECIAL_FLAG_EN
    compared++;
    if (special_flag !== 1'b0) begin
      mismatched++; $display("FAIL reset_flag: got %b want 0", special_flag);
    end
`endif
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_directed();
    logic [63:0]   vin[10];
    logic [OW-1:0] vexp[10];
    bit            vflag[10];
    logic [127:0]  one;
    logic [OW-1:0] e;
    int            a;
    bit            fl;
    int            idx;
    one = 128'd1;
    vin[0] = 64'h3FF0000000000000; vexp[0] = mk(1'b0, one << 52, 128'd0, 5'd16);  vflag[0] = 0;
    vin[1] = 64'hC000000000000000; vexp[1] = mk(1'b1, one << 53, 128'd0, 5'd16);  vflag[1] = 0;
    vin[2] = 64'h0000000000000000; vexp[2] = mk(1'b0, 128'd0, 128'd0, 5'd0);      vflag[2] = 0;
    vin[3] = 64'h8000000000000000; vexp[3] = mk(1'b1, 128'd0, 128'd0, 5'd0);      vflag[3] = 0;
    vin[4] = 64'h0000000000000001; vexp[4] = mk(1'b0, 128'd0, 128'd4, 5'd1);      vflag[4] = 0;
    vin[5] = 64'h7FEFFFFFFFFFFFFF; vexp[5] = mk(1'b0, sat_msb(), 128'd0, 5'd31);  vflag[5] = 0;
    vin[6] = 64'h7FF0000000000000; vexp[6] = mk(1'b0, sat_msb(), 128'd0, 5'd31);  vflag[6] = 1;
    vin[7] = 64'h7FF8000000000001; vexp[7] = mk(1'b0, sat_msb(), 128'd0, 5'd31);  vflag[7] = 1;
    vin[8] = 64'hFFF0000000000000; vexp[8] = mk(1'b1, sat_msb(), 128'd0, 5'd31);  vflag[8] = 1;
    vin[9] = 64'h3FE0000000000000; vexp[9] = mk(1'b0, one << 115, 128'd0, 5'd15); vflag[9] = 0;
    idx = 0;
    out_tready = 1'b1;
    for (int b = 0; b < 40 && (idx < 10 || exp_q.size() > 0); b++) begin
      @(negedge clk);
      if (idx < 10) begin
        in_tvalid = 1'b1; in_tdata = vin[idx];
      end else begin
        in_tvalid = 1'b0;
      end
      #1;
      if (out_tvalid && out_tready) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++; $display("FAIL dir_extra: got output %h want none", out_tdata);
        end else begin
          e = exp_q.pop_front(); a = acc_q.pop_front(); fl = flag_q.pop_front();
          if (out_tdata !== e) begin
            mismatched++; $display("FAIL dir_data: got %h want %h", out_tdata, e);
          end
          compared++;
          if (cyc - a !== 2) begin
            mismatched++; $display("FAIL dir_latency: got %0d want 2", cyc - a);
          end
`ifdef FP64_SPECIAL_FLAG_EN
          compared++;
          if (special_flag !== fl) begin
            mismatched++; $display("FAIL dir_flag: got %b want %b", special_flag, fl);
          end
`endif
        end
      end
      if (in_tvalid && in_tready) begin
        exp_q.push_back(vexp[idx]); acc_q.push_back(cyc); flag_q.push_back(vflag[idx]);
        idx++;
      end
    end
    in_tvalid = 1'b0;
    compared++;
    if (idx != 10 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL dir_timeout: got sent=%0d pending=%0d want sent=10 pending=0", idx, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0]   src[100];
    logic [63:0]   x;
    logic [OW-1:0] e;
    logic [OW-1:0] held;
    bit            stalled;
    int            idx;
    int            nout;
    for (int i = 0; i < 100; i++) begin
      x = {$urandom(), $urandom()};
      if (x[62:52] == 11'h7FF) x[62:52] = 11'($urandom_range(0, 2046));
      if ($urandom_range(0, 9) == 0) x[62:52] = 11'd0;
      src[i] = x;
    end
    exp_q.delete(); acc_q.delete(); flag_q.delete();
    idx = 0; nout = 0; stalled = 0; held = '0;
    for (int b = 0; b < 2000 && (idx < 100 || exp_q.size() > 0); b++) begin
      @(negedge clk);
      out_tready = ($urandom_range(0, 1) == 1);
      if (idx < 100 && $urandom_range(0, 9) != 0) begin
        in_tvalid = 1'b1; in_tdata = src[idx];
      end else begin
        in_tvalid = 1'b0;
      end
      #1;
      if (stalled) begin
        compared++;
        if (out_tvalid !== 1'b1 || out_tdata !== held) begin
          mismatched++;
          $display("FAIL b2b_stall_hold: got v=%b %h want v=1 %h", out_tvalid, out_tdata, held);
        end
      end
      compared++;
      if (in_tready !== (!out_tvalid || out_tready)) begin
        mismatched++;
        $display("FAIL b2b_in_tready: got %b want %b", in_tready, (!out_tvalid || out_tready));
      end
      if (out_tvalid && out_tready) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++; $display("FAIL b2b_extra: got output %h want none", out_tdata);
        end else begin
          e = exp_q.pop_front(); void'(acc_q.pop_front()); void'(flag_q.pop_front());
          nout++;
          if (out_tdata !== e) begin
            mismatched++; $display("FAIL b2b_data: out#%0d got %h want %h", nout, out_tdata, e);
          end
`ifdef FP64_SPECIAL_FLAG_EN
          compared++;
          if (special_flag !== 1'b0) begin
            mismatched++; $display("FAIL b2b_flag: got %b want 0", special_flag);
          end
`endif
        end
      end
      stalled = out_tvalid && !out_tready;
      held    = out_tdata;
      if (in_tvalid && in_tready) begin
        exp_q.push_back(ref_pkt(src[idx])); acc_q.push_back(cyc); flag_q.push_back(1'b0);
        idx++;
      end
    end
    in_tvalid = 1'b0;
    compared++;
    if (nout != 100 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL b2b_count: got outputs=%0d pending=%0d want 100/0", nout, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    logic [63:0]   y;
    logic [OW-1:0] e;
    bit            sent;
    bit            got;
    out_tready = 1'b1;
    @(negedge clk); in_tvalid = 1'b1; in_tdata = 64'h4000000000000000;
    @(negedge clk); in_tvalid = 1'b1; in_tdata = 64'h4008000000000000;
    @(negedge clk); in_tvalid = 1'b0; out_tready = 1'b0;
    #1;
    compared++;
    if (out_tvalid !== 1'b1) begin
      mismatched++; $display("FAIL rst_inflight: got tvalid %b want 1", out_tvalid);
    end
    rstn = 1'b0;
    #1;
    compared++;
    if (out_tvalid !== 1'b0) begin
      mismatched++; $display("FAIL rst_async_tvalid: got %b want 0", out_tvalid);
    end
    compared++;
    if (out_tdata !== '0) begin
      mismatched++; $display("FAIL rst_async_tdata: got %h want 0", out_tdata);
    end
    exp_q.delete(); acc_q.delete(); flag_q.delete();
    @(negedge clk); rstn = 1'b1;
    y = 64'hBFF8000000000000;  // -1.5
    e = ref_pkt(y);
    sent = 0; got = 0;
    out_tready = 1'b1;
    for (int b = 0; b < 12 && !got; b++) begin
      @(negedge clk);
      in_tvalid = !sent; in_tdata = y;
      #1;
      if (out_tvalid) begin
        got = 1;
        compared++;
        if (out_tdata !== e) begin
          mismatched++; $display("FAIL rst_first_out: got %h want %h", out_tdata, e);
        end
      end
      if (in_tvalid && in_tready) sent = 1;
    end
    in_tvalid = 1'b0;
    compared++;
    if (!got) begin
      mismatched++; $display("FAIL rst_first_timeout: got no output want one");
    end
    repeat (3) @(negedge clk);
    #1;
    compared++;
    if (out_tvalid !== 1'b0) begin
      mismatched++; $display("FAIL rst_no_dup: got tvalid %b want 0", out_tvalid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fp64_to_fixpkt.md
Name: fp64_to_fixpkt

Overview:
- Upstream stage of the fixed-point accumulator datapath.
- Converts one IEEE-754 binary64 value per transfer into the team's segmented fixed-point packet: {sign, msb, lmb, expo_cs}.
- Feeds the accumulator lanes; the packet is bit-exact decodable by the packet-to-fp64 normaliser downstream.
- Two-stage pipeline with full valid/ready backpressure.

Parameters:
- PRE_REG_WIDTH, 128, width of the lmb and msb fields; only 128 is supported.
- DEPTH, 32, number of exponent segments; expo_cs width is EW = clogb2(DEPTH-1) = 5.
- PRE_REG_STEP, 64, bit offset between segments; only 64 is supported.

Ports:
- clk  input  1  single clock.
- rstn  input  1  reset; asynchronous, active-low.
- fp64_in_stream  stream.slave  64  tvalid/tready/tdata carrying a binary64 value.
- ptk_out_stream  stream.master  EW+2*PRE_REG_WIDTH+1 = 262  tdata[4:0] = expo_cs, [132:5] = lmb, [260:133] = msb, [261] = sign.

Behaviour:
- Packet value = (-1)^sign * F * 2^(64*expo_cs - 1140), with F = msb*2^64 + lmb.
- Stage 1 (unpack), from input fields s, e[10:0], f[51:0]:
  - m = {e!=0, f} (53 bits).
  - Ee = max(e,1); t = Ee+1 (12 bits).
  - If t<64: k = 1, sh = t. Otherwise: k = t>>6, sh = (t & 63) + 64.
  - Classify the input as zero (e==0 and f==0), special (e==2047), or finite.
- Stage 2 (shift/pack):
  - F = m << sh, 192 bits; no overflow is possible since max bit = 52+127 = 179.
  - lmb = {64'b0, F[63:0]}; msb = F[191:64]; expo_cs = k; sign = s.
- Zero (including -0): lmb = 0, msb = 0, expo_cs = 0, sign = s.
- Special (inf or NaN): saturate to the max-normal magnitude, i.e. expo_cs = 31, msb = (2^53-1)<<63, lmb = 0, sign = s. NaN payload is discarded.
- Pipeline control:
  - adv = !s2_valid | ptk_out_stream.tready.
  - Both stages load when adv is high.
  - fp64_in_stream.tready = adv (combinational from downstream tready).
  - s1_valid <= in.tvalid when adv is high.
  - s2_valid <= s1_valid when adv is high.
- Latency and throughput:
  - Latency is exactly 2 cycles from an accepted input to out.tvalid when there is no backpressure.
  - Throughput is 1 transfer per cycle.
- Out tvalid/tdata come directly from stage-2 registers (no combinational path from input).
- While out.tvalid=1 and tready=0, out.tdata is held stable; no transfer is dropped or duplicated.
- Reset mid-operation: all valids clear immediately, in-flight data is discarded, and the first post-reset output comes from the first post-reset accepted input.
- Reset values: ptk_out_stream.tvalid = 0; all pipeline data registers = 0 (out.tdata = 0).
- Order is preserved: one output per accepted input.

Optional Feature:
- Macro FP64_SPECIAL_FLAG_EN.
- When defined:
  - Adds output port special_flag (1 bit), registered and aligned with ptk_out_stream.tvalid.
  - special_flag = 1 for inf/NaN inputs (the packet is still saturated as above) and 0 otherwise.
  - special_flag resets to 0.
- When undefined: the port is absent and specials are silently saturated.

Test Plan:
- 1.0 (0x3FF0000000000000) -> expo_cs=16, msb=1<<52, lmb=0, sign=0, tvalid 2 cycles after acceptance.
- -2.0 (0xC000000000000000) -> expo_cs=16, msb=1<<53, lmb=0, sign=1. Also +0 / -0 -> all fields 0 with sign 0 / 1 respectively.
- Min subnormal 0x0000000000000001 -> expo_cs=1, lmb=4, msb=0. Max normal 0x7FEFFFFFFFFFFFFF -> expo_cs=31, msb=(2^53-1)<<63, lmb=0.
- +inf 0x7FF0000000000000 and NaN 0x7FF8000000000001 -> the max-normal packet with sign 0; with FP64_SPECIAL_FLAG_EN, special_flag=1 only on those beats.
- Back-to-back stream of 100 random finite values with random out.tready (~50%):
  - every output matches a software reference, in order, with no loss or duplication;
  - tdata is stable while stalled;
  - in.tready=0 whenever s2_valid=1 and out.tready=0.
- Assert rstn low with 2 transfers in flight -> tvalid drops to 0 asynchronously, tdata=0; after release, the first output equals the first newly accepted input's packet.
